// File: rtl/pc_fetch_sequencer.sv
// Fetch controller for the word-addressed PC: drives the next PC every cycle, runs the
// imem req/ack handshake and resolves stall, branch, jump, jr and fault redirects.
module pc_fetch_sequencer #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-3:0] EXC_VECTOR  = 'h20,
    parameter int unsigned      ACK_TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic [WIDTH-3:0] i_pc,
    output logic [WIDTH-3:0] o_next_address,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_ack,
    input  logic [31:0]      i_imem_rdata,
    output logic [31:0]      o_instr,
    output logic             o_instr_valid,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [15:0]      i_branch_off,
    input  logic             i_jump,
    input  logic [25:0]      i_jump_index,
    input  logic             i_jr,
    input  logic [WIDTH-1:0] i_jr_target,
    input  logic             i_exception,
    output logic             o_fault,
    output logic [1:0]       o_fault_cause,
    output logic [WIDTH-3:0] o_epc
);

    localparam int unsigned PW = WIDTH - 2;
    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StStall = 2'd2;
    localparam logic [1:0] StFault = 2'd3;

    localparam logic [1:0] CauseTimeout = 2'b01;
    localparam logic [1:0] CauseJrAlign = 2'b10;
    localparam logic [1:0] CauseExc     = 2'b11;

    localparam logic [CW-1:0] TimeoutLast = CW'(ACK_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [31:0]   instr_buf_q, instr_buf_d;
    logic [PW-1:0] epc_q, epc_d;
    logic [1:0]    cause_q, cause_d;

    logic          in_fetch;
    logic          in_stall;
    logic          retire;
    logic          jr_misaligned;
    logic          timeout;
    logic [PW-1:0] pcp1;
    logic [PW-1:0] branch_off_ext;
    logic [PW-1:0] next_address;

    always_comb begin
        in_fetch       = (state_q == StFetch);
        in_stall       = (state_q == StStall);
        retire         = (in_fetch && i_imem_ack) || in_stall;
        jr_misaligned  = i_jr && (i_jr_target[1:0] != 2'b00);
        timeout        = in_fetch && !i_imem_ack && (wait_q == TimeoutLast);
        pcp1           = i_pc + PW'(1);
        branch_off_ext = {{(PW - 16){i_branch_off[15]}}, i_branch_off};

        state_d      = state_q;
        wait_d       = '0;
        instr_buf_d  = instr_buf_q;
        epc_d        = epc_q;
        cause_d      = 2'b00;
        next_address = i_pc;

        // Capture on the ack cycle so a stall can replay the word after imem moves on.
        if (in_fetch && i_imem_ack) begin
            instr_buf_d = i_imem_rdata;
        end

        case (state_q)
            StBoot: begin
                state_d = StFetch;
            end
            StFault: begin
                state_d      = StFetch;
                next_address = EXC_VECTOR;
            end
            default: begin
                if (retire) begin
                    if (i_exception) begin
                        state_d = StFault;
                        cause_d = CauseExc;
                        epc_d   = i_pc;
                    end else if (jr_misaligned) begin
                        state_d = StFault;
                        cause_d = CauseJrAlign;
                        epc_d   = i_pc;
                    end else if (i_stall) begin
                        state_d = StStall;
                    end else begin
                        state_d = StFetch;
                        if (i_jr) begin
                            next_address = i_jr_target[WIDTH-1:2];
                        end else if (i_jump) begin
                            next_address = {pcp1[PW-1:26], i_jump_index};
                        end else if (i_branch_taken) begin
                            next_address = pcp1 + branch_off_ext;
                        end else begin
                            next_address = pcp1;
                        end
                    end
                end else if (timeout) begin
                    state_d = StFault;
                    cause_d = CauseTimeout;
                    epc_d   = i_pc;
                end else if (in_fetch) begin
                    wait_d = wait_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q     <= StBoot;
            wait_q      <= '0;
            instr_buf_q <= '0;
            epc_q       <= '0;
            cause_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            instr_buf_q <= instr_buf_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
        end
    end

    // cause_q is only ever non-zero while sitting in the FAULT cycle.
    always_comb begin
        o_next_address = next_address;
        o_imem_req     = in_fetch;
        o_imem_addr    = {i_pc, 2'b00};
        o_instr_valid  = retire;
        o_instr        = in_stall ? instr_buf_q : i_imem_rdata;
        o_fault        = (state_q == StFault);
        o_fault_cause  = cause_q;
        o_epc          = epc_q;
    end

endmodule
